divm_prog: RTL and testbench

Parametrised, runtime-programmable successor to the fixed divide-by-M clock divider. Produces a divided clock-enable waveform (clk_out) and a one-cycle period tick from the system clock. The divisor is reloadable without glitches through a shadow register that updates only on a period boundary. Supports continuous and one-shot modes. Used as the timebase generator for downstream sequencers and serial blocks.

---
 rtl/divm_pkg.sv | 13 +
 rtl/divm_shadow.sv | 53 +++++
 rtl/divm_prog.sv | 78 +++++++
 tb/tb_divm_prog.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divm_pkg.sv
// Shared constants and state encoding for the programmable divide-by-M timebase.
package divm_pkg;

  localparam logic        MODE_CONT    = 1'b0;
  localparam logic        MODE_ONESHOT = 1'b1;
  localparam int unsigned DIV_MIN      = 2;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/divm_shadow.sv
// Divisor shadow register: holds a pending divisor until a period boundary,
// clamps divisors below DIV_MIN and pulses div_ack after the swap.
module divm_shadow
  import divm_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  input  logic             boundary,
  output logic [WIDTH-1:0] d_active,
  output logic [WIDTH-1:0] d_next_c,
  output logic             div_ack
);

  logic [WIDTH-1:0] val_clamped_c;
  logic [WIDTH-1:0] pend_val;
  logic             pend_valid;
  logic             apply_c;

  // Clamp the incoming value and pick the divisor that is active after this edge
  always_comb begin
    val_clamped_c = (div_val < WIDTH'(DIV_MIN)) ? WIDTH'(DIV_MIN) : div_val;
    apply_c       = boundary && (div_load || pend_valid);
    d_next_c      = d_active;
    if (apply_c) begin
      d_next_c = div_load ? val_clamped_c : pend_val;
    end
  end

  // Active divisor, pending slot and acknowledge pulse
  always_ff @(posedge clk_in) begin
    if (reset) begin
      d_active   <= WIDTH'(DEFAULT_DIV);
      pend_val   <= '0;
      pend_valid <= 1'b0;
      div_ack    <= 1'b0;
    end else begin
      d_active <= d_next_c;
      div_ack  <= apply_c;
      if (apply_c) begin
        pend_valid <= 1'b0;
      end else if (div_load) begin
        pend_valid <= 1'b1;
        pend_val   <= val_clamped_c;
      end
    end
  end

endmodule

// File: rtl/divm_prog.sv
// Runtime-programmable divide-by-M clock-enable generator with continuous
// and one-shot modes; outputs always describe the current counter value.
module divm_prog
  import divm_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] d_active;
  logic [WIDTH-1:0] d_next_c;
  logic [WIDTH-1:0] cnt_next_c;
  logic             at_last_c;
  logic             boundary_c;
  logic             go_c;
  logic             stop_c;

  divm_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_shadow (
    .clk_in   (clk_in),
    .reset    (reset),
    .div_val  (div_val),
    .div_load (div_load),
    .boundary (boundary_c),
    .d_active (d_active),
    .d_next_c (d_next_c),
    .div_ack  (div_ack)
  );

  // Period boundary, start/stop decisions and next counter value
  always_comb begin
    at_last_c  = (state == RUN) && (cnt == d_active - WIDTH'(1));
    boundary_c = (state == STOP) || at_last_c;
    go_c       = enable && ((mode == MODE_CONT) || start);
    stop_c     = (state == RUN) && (!enable || (at_last_c && (mode == MODE_ONESHOT)));
    cnt_next_c = ((state == RUN) && !at_last_c) ? cnt + WIDTH'(1) : '0;
  end

  // State, counter and registered outputs derived from the post-edge count
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state   <= STOP;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
    end else if (((state == STOP) && !go_c) || stop_c) begin
      state   <= STOP;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= RUN;
      cnt     <= cnt_next_c;
      clk_out <= (cnt_next_c < (d_next_c >> 1));
      tick    <= (cnt_next_c == d_next_c - WIDTH'(1));
      busy    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divm_prog.sv
// Self-checking bench for divm_prog: period-level reference model plus
// directed literal expectations, then randomized traffic.
module tb_divm_prog;

  logic       clk_in = 1'b0;
  logic       reset, enable, mode, start, div_load;
  logic [7:0] div_val;
  logic       div_ack, clk_out, tick, busy;

  int checks   = 0;
  int failures = 0;

  // reference model state: running flag, position in period, divisor, pending slot
  int m_run = 0, m_pos = 0, m_d = 4, m_pv = 0, m_pval = 0, m_ack = 0;
  int nd, na;
  bit bnd;

  bit chk_en = 1'b0;
  bit lit_en = 1'b0;
  bit lit_c, lit_t, lit_b, lit_a;

  divm_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .start    (start),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  function automatic int clamp(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // reference model advanced on every rising edge
  always @(posedge clk_in) begin
    if (reset) begin
      m_run = 0; m_pos = 0; m_d = 4; m_pv = 0; m_pval = 0; m_ack = 0;
    end else begin
      bnd = (m_run == 0) || (m_pos == m_d - 1);
      nd  = m_d;
      na  = 0;
      if (bnd && (div_load || m_pv != 0)) begin
        nd   = div_load ? clamp(int'(div_val)) : m_pval;
        m_pv = 0;
        na   = 1;
      end else if (div_load) begin
        m_pv   = 1;
        m_pval = clamp(int'(div_val));
      end
      if (m_run == 0) begin
        if (enable && (!mode || start)) begin m_run = 1; m_pos = 0; end
      end else if (!enable) begin
        m_run = 0; m_pos = 0;
      end else if (m_pos == m_d - 1) begin
        m_pos = 0;
        if (mode) m_run = 0;
      end else begin
        m_pos = m_pos + 1;
      end
      m_d   = nd;
      m_ack = na;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // single compare process, sampling on the falling edge
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("clk_out", 32'(clk_out), 32'((m_run != 0) && (m_pos < m_d / 2)));
      chk("tick",    32'(tick),    32'((m_run != 0) && (m_pos == m_d - 1)));
      chk("busy",    32'(busy),    32'(m_run != 0));
      chk("div_ack", 32'(div_ack), 32'(m_ack != 0));
      if (lit_en) begin
        chk("lit_clk_out", 32'(clk_out), 32'(lit_c));
        chk("lit_tick",    32'(tick),    32'(lit_t));
        chk("lit_busy",    32'(busy),    32'(lit_b));
        chk("lit_div_ack", 32'(div_ack), 32'(lit_a));
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic post(input bit c, input bit t, input bit b, input bit a);
    lit_c = c; lit_t = t; lit_b = b; lit_a = a;
    lit_en = 1'b1;
  endtask

  task automatic wait_until(input int d, input int p);
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (m_run == 1 && m_d == d && m_pos == p) hit = 1'b1;
      else step();
    end
    if (!hit) begin
      $display("FAIL wait_until d=%0d pos=%0d timed out", d, p);
      $fatal(1, "bench stuck");
    end
  endtask

  task automatic wait_stop();
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (m_run == 0) hit = 1'b1;
      else step();
    end
    if (!hit) begin
      $display("FAIL wait_stop timed out");
      $fatal(1, "bench stuck");
    end
  endtask

  initial begin
    logic [7:0] clk_pat;
    logic [7:0] tick_pat;
    clk_pat  = 8'b0011_0011;
    tick_pat = 8'b1000_1000;
    reset = 1'b1; enable = 1'b0; mode = 1'b0; start = 1'b0;
    div_load = 1'b0; div_val = 8'd0;
    step(); step();
    chk_en = 1'b1;
    post(0, 0, 0, 0);
    reset = 1'b0; enable = 1'b1; mode = 1'b0;

    // continuous D=4 from reset
    for (int i = 0; i < 8; i++) begin
      step();
      post(clk_pat[i], tick_pat[i], 1, 0);
    end

    // load 5 while running, applied at the next wrap
    step(); post(1, 0, 1, 0);
    div_load = 1'b1; div_val = 8'd5;
    step(); post(1, 0, 1, 0);
    div_load = 1'b0;
    step(); post(0, 0, 1, 0);
    step(); post(0, 1, 1, 0);
    step(); post(1, 0, 1, 1);
    step(); post(1, 0, 1, 0);
    step(); post(0, 0, 1, 0);
    step(); post(0, 0, 1, 0);
    step(); post(0, 1, 1, 0);
    step(); post(1, 0, 1, 0);

    // back to D=4, then load 6 at cnt=1
    div_load = 1'b1; div_val = 8'd4;
    step();
    div_load = 1'b0;
    wait_until(4, 1);
    div_load = 1'b1; div_val = 8'd6;
    step(); post(0, 0, 1, 0);
    div_load = 1'b0;
    step(); post(0, 1, 1, 0);
    step(); post(1, 0, 1, 1);
    step(); post(1, 0, 1, 0);
    step(); post(1, 0, 1, 0);
    step(); post(0, 0, 1, 0);
    step(); post(0, 0, 1, 0);
    step(); post(0, 1, 1, 0);
    step(); post(1, 0, 1, 0);

    // one-shot D=3 with a repeated start while busy
    mode = 1'b1;
    wait_stop();
    div_load = 1'b1; div_val = 8'd3;
    step();
    div_load = 1'b0;
    step(); step();
    start = 1'b1;
    step(); post(1, 0, 1, 0);
    step(); post(0, 0, 1, 0);
    start = 1'b0;
    step(); post(0, 1, 1, 0);
    step(); post(0, 0, 0, 0);
    step(); post(0, 0, 0, 0);

    // clamp of 0 and 1, then back-to-back loads 7 and 9
    mode = 1'b0; div_load = 1'b1; div_val = 8'd0;
    step(); post(1, 0, 1, 1);
    div_load = 1'b0;
    step(); post(0, 1, 1, 0);
    step(); post(1, 0, 1, 0);
    step(); post(0, 1, 1, 0);
    div_load = 1'b1; div_val = 8'd1;
    step(); post(1, 0, 1, 1);
    div_load = 1'b0;
    step(); post(0, 1, 1, 0);
    step(); post(1, 0, 1, 0);
    div_load = 1'b1; div_val = 8'd7;
    step(); post(0, 1, 1, 0);
    div_val = 8'd9;
    step(); post(1, 0, 1, 1);
    div_load = 1'b0;
    step(); post(1, 0, 1, 0);
    step(); post(1, 0, 1, 0);
    step(); post(1, 0, 1, 0);
    step(); post(0, 0, 1, 0);

    // enable drop at cnt=2, restart, then reset mid-period with a pending load
    wait_until(9, 2);
    enable = 1'b0;
    step(); post(0, 0, 0, 0);
    enable = 1'b1;
    step(); post(1, 0, 1, 0);
    step();
    div_load = 1'b1; div_val = 8'd7;
    step(); post(1, 0, 1, 0);
    div_load = 1'b0; reset = 1'b1;
    step(); post(0, 0, 0, 0);
    reset = 1'b0;
    step(); post(1, 0, 1, 0);
    step(); post(1, 0, 1, 0);
    step(); post(0, 0, 1, 0);
    step(); post(0, 1, 1, 0);
    step(); post(1, 0, 1, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom % 250) == 0;
      enable   = ($urandom % 20) != 0;
      if (($urandom % 40) == 0) mode = ~mode;
      start    = ($urandom % 8) == 0;
      div_load = ($urandom % 10) == 0;
      div_val  = (($urandom % 10) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 12));
      step();
    end
    reset = 1'b0; div_load = 1'b0; start = 1'b0;
    step(); step();
    @(negedge clk_in);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
